// File: rtl/fully_connected.sv
// Fully connected layer: one neuron at a time, sum_k x[k]*w[n][k] plus bias, Q-format result.
// Latency: INPUT_SIZE+3 cycles per neuron (CLEAR..STORE) with valids high; result strobe the cycle after STORE.
// Backpressure: ACCUM stalls while input_valid or weight_valid is low, BIAS stalls while weight_valid is low.
module fully_connected #(
    parameter int INPUT_SIZE  = 30720,
    parameter int OUTPUT_SIZE = 10,
    parameter int FRAC_BITS   = 8,
    localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
    localparam int WW = (OUTPUT_SIZE * (INPUT_SIZE + 1) > 1) ? $clog2(OUTPUT_SIZE * (INPUT_SIZE + 1)) : 1,
    localparam int NW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [15:0]   input_data,
    output logic [IW-1:0]        input_addr,
    input  logic                 input_valid,
    input  logic signed [15:0]   weight_data,
    output logic [WW-1:0]        weight_addr,
    input  logic                 weight_valid,
    output logic signed [15:0]   fc_output,
    output logic [NW-1:0]        output_addr,
    output logic                 output_valid,
    output logic                 fc_done
);

    // Accumulator is wide enough to sum INPUT_SIZE full products plus the bias without overflow.
    localparam int AW = 32 + $clog2(INPUT_SIZE) + 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = -AW'(32768);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        BIAS  = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [NW-1:0]         n;
    logic signed [AW-1:0]  acc;
    logic signed [31:0]    prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  bias_ext;
    logic signed [AW-1:0]  shifted;
    logic                  consume;
    logic                  k_last;
    logic                  n_last;

    // The element index k is carried by input_addr itself; both always move together.
    assign consume  = input_valid & weight_valid;
    assign k_last   = (input_addr == IW'(INPUT_SIZE - 1));
    assign n_last   = (n == NW'(OUTPUT_SIZE - 1));
    assign prod     = input_data * weight_data;
    assign prod_ext = $signed({{(AW - 32){prod[31]}}, prod});
    assign bias_ext = $signed({{(AW - 16){weight_data[15]}}, weight_data}) <<< FRAC_BITS;
    assign shifted  = acc >>> FRAC_BITS;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = CLEAR;
            CLEAR:   state_d = ACCUM;
            ACCUM:   if (consume && k_last) state_d = BIAS;
            BIAS:    if (weight_valid) state_d = STORE;
            STORE:   state_d = n_last ? DONE : CLEAR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: addresses, accumulation, saturating result register and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            n            <= '0;
            acc          <= '0;
            input_addr   <= '0;
            weight_addr  <= '0;
            fc_output    <= '0;
            output_addr  <= '0;
            output_valid <= 1'b0;
            fc_done      <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            fc_done      <= 1'b0;
            case (state_q)
                CLEAR: begin
                    acc         <= '0;
                    input_addr  <= '0;
                    weight_addr <= WW'(n * (INPUT_SIZE + 1));
                end
                ACCUM: begin
                    if (consume) begin
                        acc <= acc + prod_ext;
                        // On the last element this step lands exactly on the bias word.
                        weight_addr <= weight_addr + WW'(1);
                        if (!k_last) begin
                            input_addr <= input_addr + IW'(1);
                        end
                    end
                end
                BIAS: begin
                    if (weight_valid) begin
                        acc <= acc + bias_ext;
                    end
                end
                STORE: begin
                    if (shifted > SAT_MAX) begin
                        fc_output <= 16'sh7FFF;
                    end else if (shifted < SAT_MIN) begin
                        fc_output <= -16'sh8000;
                    end else begin
                        fc_output <= shifted[15:0];
                    end
                    output_addr  <= n;
                    output_valid <= 1'b1;
                    if (n_last) begin
                        fc_done <= 1'b1;
                    end else begin
                        n <= n + NW'(1);
                    end
                end
                DONE: begin
                    n <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fully_connected.sv
// Directed bench for fully_connected with INPUT_SIZE=4, OUTPUT_SIZE=2, FRAC_BITS=8.
// Vector table drives whole runs; extra runs cover stalls, enable toggling and mid-run reset.
// Outputs sampled on the falling edge; expected values are hand-computed constants.
module tb_fully_connected;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] input_data;
    logic [1:0]         input_addr;
    logic               input_valid;
    logic signed [15:0] weight_data;
    logic [3:0]         weight_addr;
    logic               weight_valid;
    logic signed [15:0] fc_output;
    logic [0:0]         output_addr;
    logic               output_valid;
    logic               fc_done;

    logic [15:0] cur_in, cur_in3, cur_w0, cur_b0, cur_w1, cur_b1;
    logic [15:0] fo_u;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] in_v;
        logic [15:0] in3;
        logic [15:0] w0;
        logic [15:0] b0;
        logic [15:0] w1;
        logic [15:0] b1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vt[7];

    fully_connected #(
        .INPUT_SIZE (4),
        .OUTPUT_SIZE(2),
        .FRAC_BITS  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .input_data  (input_data),
        .input_addr  (input_addr),
        .input_valid (input_valid),
        .weight_data (weight_data),
        .weight_addr (weight_addr),
        .weight_valid(weight_valid),
        .fc_output   (fc_output),
        .output_addr (output_addr),
        .output_valid(output_valid),
        .fc_done     (fc_done)
    );

    // Memory models: element 3 may differ; words 4 and 9 are the biases.
    assign input_data  = (input_addr == 2'd3) ? cur_in3 : cur_in;
    assign weight_data = (weight_addr == 4'd4) ? cur_b0 :
                         (weight_addr == 4'd9) ? cur_b1 :
                         (weight_addr < 4'd5)  ? cur_w0 : cur_w1;
    assign fo_u = fc_output;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One full enable-to-idle run observed over a fixed 30-cycle window.
    task automatic run(input int vi, input bit stall, input bit tog, input int rst_at);
        int np, nd, dcyc, d, st_start;
        int pcyc[2];
        logic [15:0] pout[2];
        logic [0:0]  paddr[2];
        bit stalled;
        np = 0; nd = 0; dcyc = 0; st_start = 0; stalled = 0;
        d = stall ? 3 : 0;
        pcyc[0] = 0; pcyc[1] = 0; pout[0] = '0; pout[1] = '0; paddr[0] = '0; paddr[1] = '0;
        cur_in = vt[vi].in_v; cur_in3 = vt[vi].in3;
        cur_w0 = vt[vi].w0; cur_b0 = vt[vi].b0;
        cur_w1 = vt[vi].w1; cur_b1 = vt[vi].b1;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        for (int cnt = 1; cnt <= 30; cnt++) begin
            @(negedge clk);
            if (tog) enable = (cnt >= 3 && cnt <= 12 && (cnt % 2 == 1));
            if (stall) begin
                if (stalled && cnt > st_start && cnt <= st_start + 3) begin
                    chk("stall_in_addr_hold", 32'(input_addr), 32'd2);
                    chk("stall_w_addr_hold", 32'(weight_addr), 32'd2);
                end
                if (!stalled && cnt >= 2 && input_addr == 2'd2) begin
                    input_valid = 1'b0;
                    stalled = 1'b1;
                    st_start = cnt;
                end
                if (stalled && cnt == st_start + 3) input_valid = 1'b1;
            end
            if (rst_at != 0 && cnt == rst_at) reset = 1'b1;
            if (rst_at != 0 && cnt == rst_at + 1) begin
                chk("rst_mid_fc_output", 32'(fo_u), 32'd0);
                chk("rst_mid_output_addr", 32'(output_addr), 32'd0);
                chk("rst_mid_output_valid", 32'(output_valid), 32'd0);
                chk("rst_mid_fc_done", 32'(fc_done), 32'd0);
                chk("rst_mid_input_addr", 32'(input_addr), 32'd0);
                chk("rst_mid_weight_addr", 32'(weight_addr), 32'd0);
                reset = 1'b0;
            end
            if (output_valid) begin
                if (np < 2) begin
                    pcyc[np]  = cnt;
                    pout[np]  = fo_u;
                    paddr[np] = output_addr;
                end
                np++;
            end
            if (fc_done) begin
                nd++;
                dcyc = cnt;
            end
        end
        enable = 1'b0;
        if (rst_at != 0) begin
            chk("rst_run_pulses", 32'(np), 32'd1);
            chk("rst_run_done", 32'(nd), 32'd0);
            chk("rst_run_out_zero", 32'(fo_u), 32'd0);
        end else begin
            chk("pulse_count", 32'(np), 32'd2);
            chk("done_count", 32'(nd), 32'd1);
            chk("pulse0_cycle", 32'(pcyc[0]), 32'(8 + d));
            chk("pulse1_cycle", 32'(pcyc[1]), 32'(15 + d));
            chk("done_cycle", 32'(dcyc), 32'(15 + d));
            chk("out0", 32'(pout[0]), 32'(vt[vi].e0));
            chk("out1", 32'(pout[1]), 32'(vt[vi].e1));
            chk("addr0", 32'(paddr[0]), 32'd0);
            chk("addr1", 32'(paddr[1]), 32'd1);
            chk("out_hold", 32'(fo_u), 32'(vt[vi].e1));
            chk("addr_hold", 32'(output_addr), 32'd1);
        end
    endtask

    initial begin
        int stray;
        //           in_v      in3       w0        b0        w1        b1        e0        e1
        vt[0] = '{16'h0100, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100, 16'h0300, 16'h0300};
        vt[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        vt[2] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
        vt[3] = '{16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'hFF00, 16'h0010, 16'h0400, 16'hFC10};
        vt[4] = '{16'h0200, 16'h0200, 16'h0040, 16'hFFFF, 16'h0000, 16'h8000, 16'h01FF, 16'h8000};
        vt[5] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000};
        vt[6] = '{16'h0100, 16'h0300, 16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0600, 16'h0300};

        reset = 1'b1; enable = 1'b0; input_valid = 1'b1; weight_valid = 1'b1;
        cur_in = '0; cur_in3 = '0; cur_w0 = '0; cur_b0 = '0; cur_w1 = '0; cur_b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fc_output", 32'(fo_u), 32'd0);
        chk("rst_output_addr", 32'(output_addr), 32'd0);
        chk("rst_output_valid", 32'(output_valid), 32'd0);
        chk("rst_fc_done", 32'(fc_done), 32'd0);
        chk("rst_input_addr", 32'(input_addr), 32'd0);
        chk("rst_weight_addr", 32'(weight_addr), 32'd0);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (output_valid || fc_done) stray++;
        end
        chk("no_pulse_after_reset", 32'(stray), 32'd0);

        for (int i = 0; i < 7; i++) run(i, 1'b0, 1'b0, 0);
        run(0, 1'b1, 1'b0, 0);
        run(0, 1'b0, 1'b1, 0);
        run(0, 1'b0, 1'b0, 10);
        run(0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
